// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
// Operand magnitude is computed on a 64-bit carrier and sized by the caller.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mstate_t;

  function automatic logic [63:0] abs_n(
    input logic [63:0] v,
    input int unsigned w,
    input logic        s
  );
    logic [63:0] m;
    logic [63:0] t;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    t = v >> (w - 1);
    // -2^(w-1) negates to itself and reads back as +2^(w-1) unsigned
    if (s && t[0])
      abs_n = (~v + 64'd1) & m;
    else
      abs_n = v & m;
  endfunction

endpackage

// File: rtl/seqmultiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock.
// Signed mode multiplies magnitudes and negates the product at the end.
module seqmultiplier
  import mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clock,
  input  logic           n_reset,
  input  logic           start,
  input  logic           sgn,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           ready,
  output logic           done,
  output logic [2*N-1:0] Q
);

  localparam int CW = $clog2(N + 1);

  mstate_t        state_q, state_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d;
  logic [2*N-1:0] q_q, q_d;
  logic [N:0]     sum;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    q_d      = q_q;
    sum      = '0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = N'(abs_n(64'(A), N, sgn));
          mplier_d = N'(abs_n(64'(B), N, sgn));
          neg_d    = sgn & (A[N-1] ^ B[N-1]);
          acc_d    = '0;
          cnt_d    = CW'(N);
          state_d  = RUN;
        end
      end
      RUN: begin
        sum = {1'b0, acc_q[2*N-1:N]}
            + ({1'b0, mcand_q} & {(N+1){mplier_q[0]}});
        acc_d    = {sum, acc_q[N-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_d     = neg_q ? (~acc_d + (2*N)'(1)) : acc_d;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      q_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      q_q      <= q_d;
    end
  end

  assign ready = (state_q != RUN);
  assign done  = (state_q == DONE);
  assign Q     = q_q;

endmodule

// File: tb/tb_seqmultiplier.sv
// Bench for seqmultiplier: N=4 and N=8 instances checked
// against a behavioural product model through a result queue.
module tb_seqmultiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4_n, st4, sg4, rdy4, dn4;
  logic [3:0] a4, b4;
  logic [7:0] q4;

  logic        rst8_n, st8, sg8, rdy8, dn8;
  logic [7:0]  a8, b8;
  logic [15:0] q8;

  logic [63:0] exp4[$];
  logic [63:0] exp8[$];

  int n_tests = 0;
  int n_fail  = 0;

  seqmultiplier #(.N(4)) u4 (
    .clock  (clk),
    .n_reset(rst4_n),
    .start  (st4),
    .sgn    (sg4),
    .A      (a4),
    .B      (b4),
    .ready  (rdy4),
    .done   (dn4),
    .Q      (q4)
  );

  seqmultiplier #(.N(8)) u8 (
    .clock  (clk),
    .n_reset(rst8_n),
    .start  (st8),
    .sgn    (sg8),
    .A      (a8),
    .B      (b8),
    .ready  (rdy8),
    .done   (dn8),
    .Q      (q8)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(
    input logic [63:0] a,
    input logic [63:0] b,
    input int          n,
    input logic        s
  );
    longint sa, sb;
    logic [63:0] p, m;
    if (s) begin
      sa = $signed(a << (64 - n)) >>> (64 - n);
      sb = $signed(b << (64 - n)) >>> (64 - n);
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    p = 64'(sa * sb);
    m = (64'd1 << (2 * n)) - 64'd1;
    return p & m;
  endfunction

  function automatic logic [63:0] pop4();
    if (exp4.size() == 0) return '1;
    return exp4.pop_front();
  endfunction

  function automatic logic [63:0] pop8();
    if (exp8.size() == 0) return '1;
    return exp8.pop_front();
  endfunction

  task automatic wait4(output int lat, output int low);
    lat = 0;
    low = 0;
    while (dn4 !== 1'b1 && lat < 12) begin
      if (rdy4 === 1'b0) low++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait8(output int lat, output int low);
    lat = 0;
    low = 0;
    while (dn8 !== 1'b1 && lat < 20) begin
      if (rdy8 === 1'b0) low++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run4(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       s,
    input string      tag,
    input bit         tim
  );
    int lat, low;
    a4 = a; b4 = b; sg4 = s; st4 = 1'b1;
    exp4.push_back(model(64'(a), 64'(b), 4, s));
    @(posedge clk); #1;
    st4 = 1'b0;
    wait4(lat, low);
    chk({tag, "_done"}, 64'(dn4), 64'd1);
    if (tim) begin
      chk({tag, "_lat"}, 64'(lat), 64'd4);
      chk({tag, "_rdylow"}, 64'(low), 64'd4);
    end
    chk(tag, 64'(q4), pop4());
  endtask

  task automatic run8(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic       s,
    input string      tag
  );
    int lat, low;
    a8 = a; b8 = b; sg8 = s; st8 = 1'b1;
    exp8.push_back(model(64'(a), 64'(b), 8, s));
    @(posedge clk); #1;
    st8 = 1'b0;
    wait8(lat, low);
    chk({tag, "_done"}, 64'(dn8), 64'd1);
    chk({tag, "_lat"}, 64'(lat), 64'd8);
    chk(tag, 64'(q8), pop8());
  endtask

  initial begin
    int lat, low;
    rst4_n = 1'b0; st4 = 1'b0; sg4 = 1'b0; a4 = '0; b4 = '0;
    rst8_n = 1'b0; st8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
    #12;
    chk("rst4_ready", 64'(rdy4), 64'd1);
    chk("rst4_done", 64'(dn4), 64'd0);
    chk("rst4_q", 64'(q4), 64'd0);
    chk("rst8_ready", 64'(rdy8), 64'd1);
    chk("rst8_done", 64'(dn8), 64'd0);
    chk("rst8_q", 64'(q8), 64'd0);
    @(negedge clk);
    rst4_n = 1'b1;
    rst8_n = 1'b1;
    @(posedge clk); #1;

    run4(4'd15, 4'd15, 1'b0, "u15x15", 1'b1);
    chk("u15x15_const", 64'(q4), 64'hE1);
    run4(4'b1000, 4'b1000, 1'b1, "s_m8xm8", 1'b1);
    chk("s_m8xm8_const", 64'(q4), 64'h40);
    run4(4'b1000, 4'b0111, 1'b1, "s_m8x7", 1'b0);
    chk("s_m8x7_const", 64'(q4), 64'hC8);
    run4(4'b1111, 4'b0001, 1'b1, "s_m1x1", 1'b0);
    chk("s_m1x1_const", 64'(q4), 64'hFF);

    // start pulse mid-RUN with new operands must be ignored
    a4 = 4'd3; b4 = 4'd5; sg4 = 1'b0; st4 = 1'b1;
    exp4.push_back(model(64'd3, 64'd5, 4, 1'b0));
    @(posedge clk); #1;
    st4 = 1'b0; a4 = 4'd9; b4 = 4'd9;
    @(posedge clk); #1;
    st4 = 1'b1;
    @(posedge clk); #1;
    st4 = 1'b0;
    wait4(lat, low);
    chk("ign_lat", 64'(lat), 64'd2);
    chk("ign_q", 64'(q4), pop4());
    chk("ign_const", 64'(q4), 64'h0F);

    // N=8: start held high from the first accept through DONE
    a8 = 8'hFF; b8 = 8'h00; sg8 = 1'b0; st8 = 1'b1;
    exp8.push_back(model(64'hFF, 64'h00, 8, 1'b0));
    @(posedge clk); #1;
    b8 = 8'hFF;
    exp8.push_back(model(64'hFF, 64'hFF, 8, 1'b0));
    wait8(lat, low);
    chk("z_done", 64'(dn8), 64'd1);
    chk("z_lat", 64'(lat), 64'd8);
    chk("z_q", 64'(q8), pop8());
    @(posedge clk); #1;
    chk("bb_done_drop", 64'(dn8), 64'd0);
    chk("bb_ready_drop", 64'(rdy8), 64'd0);
    chk("bb_q_hold", 64'(q8), 64'd0);
    st8 = 1'b0;
    wait8(lat, low);
    chk("bb_lat", 64'(lat), 64'd8);
    chk("bb_q", 64'(q8), pop8());
    chk("bb_const", 64'(q8), 64'hFE01);

    // async reset between edges, three cycles into RUN
    a8 = 8'd100; b8 = 8'd200; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #2;
    rst8_n = 1'b0;
    #1;
    chk("ar_q", 64'(q8), 64'd0);
    chk("ar_done", 64'(dn8), 64'd0);
    chk("ar_ready", 64'(rdy8), 64'd1);
    @(negedge clk);
    rst8_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_idle_done", 64'(dn8), 64'd0);
    run8(8'd7, 8'd6, 1'b0, "ar_7x6");
    chk("ar_7x6_const", 64'(q8), 64'd42);
    run8(8'h80, 8'h80, 1'b1, "s8_min");
    run8(8'h80, 8'h7F, 1'b1, "s8_minmax");

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          run4(4'(a), 4'(b), 1'(s), "sweep", 1'b0);

    chk("q4_empty", 64'(exp4.size()), 64'd0);
    chk("q8_empty", 64'(exp8.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
